// File: rtl/conv3x3_channel_mac_if.sv
// Handshake and configuration bundle between a window producer and the
// conv3x3_channel_mac consumer.
interface conv3x3_channel_mac_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 64,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 32
) ();
   localparam int NUM_W = NUM_CHANNELS * 9;
   localparam int AW    = $clog2(NUM_W);

   logic [NUM_CHANNELS*9*DATA_WIDTH-1:0] win_in;
   logic                                 win_valid;
   logic                                 win_ready;
   logic                                 wt_wr_en;
   logic [AW-1:0]                        wt_wr_addr;
   logic [WEIGHT_WIDTH-1:0]              wt_wr_data;
   logic [ACC_WIDTH-1:0]                 bias;
   logic [DATA_WIDTH-1:0]                pix_out;
   logic                                 pix_valid;
   logic                                 pix_ready;
   logic                                 busy;

   modport slave (
      input  win_in, win_valid, wt_wr_en, wt_wr_addr, wt_wr_data, bias, pix_ready,
      output win_ready, pix_out, pix_valid, busy
   );

   modport master (
      output win_in, win_valid, wt_wr_en, wt_wr_addr, wt_wr_data, bias, pix_ready,
      input  win_ready, pix_out, pix_valid, busy
   );
endinterface

// File: rtl/conv3x3_channel_mac.sv
// One output-feature pixel per multi-channel 3x3 window: channel-multiplexed MAC,
// bias, arithmetic requantise shift, ReLU and saturation.
//
// state | meaning
// IDLE  | waiting for a window; weight writes accepted
// ACC   | accumulating LANES channels per cycle, grp = current channel group
// OUT   | result held on pix_out until downstream takes it
module conv3x3_channel_mac #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 64,
   parameter int LANES        = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 32,
   parameter int SHIFT        = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   conv3x3_channel_mac_if.slave bus
);
   localparam int G      = NUM_CHANNELS / LANES;
   localparam int GW     = (G > 1) ? $clog2(G) : 1;
   localparam int NUM_W  = NUM_CHANNELS * 9;
   localparam int AW     = $clog2(NUM_W);
   localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t state, next_state;

   logic        [GW-1:0]           grp;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic        [DATA_WIDTH-1:0]   win_px  [NUM_W];
   logic signed [WEIGHT_WIDTH-1:0] weights [NUM_W];
   logic        [DATA_WIDTH-1:0]   pix_q;
   logic                           pix_valid_q;
   logic                           started;
   logic                           win_ready;
   logic                           accept;
   logic                           last_grp;
   logic signed [ACC_WIDTH-1:0]    psum;
   logic signed [ACC_WIDTH-1:0]    sum_s;
   logic signed [ACC_WIDTH-1:0]    shifted;
   logic        [DATA_WIDTH-1:0]   sat_pix;

   // started keeps win_ready low until the first edge after reset release
   assign win_ready     = (state == IDLE) && started;
   assign accept        = bus.win_valid && win_ready;
   assign last_grp      = (grp == GW'(G - 1));
   assign bus.win_ready = win_ready;
   assign bus.pix_out   = pix_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)        next_state = ACC;
         ACC:     if (last_grp)      next_state = OUT;
         OUT:     if (bus.pix_ready) next_state = IDLE;
         default:                    next_state = IDLE;
      endcase
   end

   always_comb begin
      logic        [AW-1:0]     idx;
      logic signed [PROD_W-1:0] prod;
      idx  = '0;
      prod = '0;
      psum = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int k = 0; k < 9; k++) begin
            idx  = AW'(int'(grp) * LANES * 9 + l * 9 + k);
            prod = $signed({1'b0, win_px[idx]}) * weights[idx];
            psum = psum + $signed({{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod});
         end
      end
      sum_s   = acc + psum;
      shifted = sum_s >>> SHIFT;
      if (shifted[ACC_WIDTH-1])              sat_pix = '0;
      else if (|shifted[ACC_WIDTH-2:DATA_WIDTH]) sat_pix = '1;
      else                                   sat_pix = shifted[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         started     <= 1'b0;
         grp         <= '0;
         acc         <= '0;
         pix_q       <= '0;
         pix_valid_q <= 1'b0;
         for (int i = 0; i < NUM_W; i++) win_px[i] <= '0;
      end else begin
         started <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < NUM_W; i++)
                     win_px[i] <= bus.win_in[i*DATA_WIDTH +: DATA_WIDTH];
                  acc <= $signed(bus.bias);
                  grp <= '0;
               end
            end
            ACC: begin
               acc <= sum_s;
               grp <= grp + 1'b1;
               if (last_grp) begin
                  grp         <= '0;
                  pix_q       <= sat_pix;
                  pix_valid_q <= 1'b1;
               end
            end
            OUT: begin
               if (bus.pix_ready) pix_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Weights only change while idle so an in-flight window sees a stable set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_W; i++) weights[i] <= '0;
      end else if (state == IDLE && bus.wt_wr_en && int'(bus.wt_wr_addr) < NUM_W) begin
         weights[bus.wt_wr_addr] <= $signed(bus.wt_wr_data);
      end
   end
endmodule
